// File: rtl/udp_pkg.sv
// udp_pkg: shared constants and state encoding for the UDP RX port filter
package udp_pkg;
   localparam logic [15:0] UDP_HDR_LEN = 16'd8;
   typedef enum logic [1:0] {IDLE, HDR, FWD, DROP} state_t;
endpackage

// File: rtl/udp_rx_port_filter_64_if.sv
// udp_rx_port_filter_64_if: UDP header handshake plus AXI-stream payload, one instance per side
interface udp_rx_port_filter_64_if #(parameter int DATA_WIDTH = 64);
   localparam int KEEP_WIDTH = DATA_WIDTH / 8;
   logic                  hdr_valid;
   logic                  hdr_ready;
   logic [31:0]           source_ip;
   logic [15:0]           source_port;
   logic [15:0]           dest_port;
   logic [15:0]           length;
   logic [DATA_WIDTH-1:0] tdata;
   logic [KEEP_WIDTH-1:0] tkeep;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic                  tuser;
   modport master(
      output hdr_valid, source_ip, source_port, dest_port, length,
      output tdata, tkeep, tvalid, tlast, tuser,
      input  hdr_ready, tready
   );
   modport slave(
      input  hdr_valid, source_ip, source_port, dest_port, length,
      input  tdata, tkeep, tvalid, tlast, tuser,
      output hdr_ready, tready
   );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: increment-only counter that sticks at all-ones
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) count <= '0;
      else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/udp_rx_port_filter_64.sv
// udp_rx_port_filter_64: forwards UDP frames whose destination port matches cfg_port,
// drains and counts everything else.
module udp_rx_port_filter_64
   import udp_pkg::*;
#(
   parameter int CNT_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [15:0]            cfg_port,
   input  logic                   cfg_enable,
   udp_rx_port_filter_64_if.slave s,
   udp_rx_port_filter_64_if.master m,
   output logic [CNT_WIDTH-1:0]   drop_count,
   output logic [CNT_WIDTH-1:0]   err_count,
   output logic                   busy
);
   state_t      state, state_nxt;
   logic [31:0] source_ip;
   logic [15:0] source_port, dest_port, length;
   logic        drop_inc, err_inc;
   logic        hdr_fire;

   assign hdr_fire = s.hdr_valid && s.hdr_ready;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state       <= IDLE;
         source_ip   <= '0;
         source_port <= '0;
         dest_port   <= '0;
         length      <= '0;
      end else begin
         state <= state_nxt;
         if (hdr_fire) begin
            source_ip   <= s.source_ip;
            source_port <= s.source_port;
            dest_port   <= s.dest_port;
            length      <= s.length - UDP_HDR_LEN;
         end
      end

   // cfg is only consulted at header accept, so mid-frame changes never touch the frame in flight
   always_comb begin
      state_nxt = state;
      drop_inc  = 1'b0;
      err_inc   = 1'b0;
      case (state)
         IDLE: if (hdr_fire) begin
            if (s.length < UDP_HDR_LEN) begin
               state_nxt = DROP;
               err_inc   = 1'b1;
            end else if (!cfg_enable || s.dest_port != cfg_port) begin
               state_nxt = DROP;
               drop_inc  = 1'b1;
            end else state_nxt = HDR;
         end
         HDR:  state_nxt = m.hdr_ready ? FWD : HDR;
         FWD:  state_nxt = (s.tvalid && m.tready && s.tlast) ? IDLE : FWD;
         DROP: state_nxt = (s.tvalid && s.tlast) ? IDLE : DROP;
         default: state_nxt = IDLE;
      endcase
   end

   assign s.hdr_ready   = rst_n && state == IDLE;
   assign s.tready      = state == DROP || (state == FWD && m.tready);
   assign m.hdr_valid   = state == HDR;
   assign m.source_ip   = source_ip;
   assign m.source_port = source_port;
   assign m.dest_port   = dest_port;
   assign m.length      = length;
   assign m.tvalid      = state == FWD && s.tvalid;
   assign m.tdata       = s.tdata;
   assign m.tkeep       = s.tkeep;
   assign m.tlast       = s.tlast;
   assign m.tuser       = s.tuser;
   assign busy          = state != IDLE;

   sat_counter #(.W(CNT_WIDTH)) u_drop (.clk(clk), .rst_n(rst_n), .inc(drop_inc), .count(drop_count));
   sat_counter #(.W(CNT_WIDTH)) u_err  (.clk(clk), .rst_n(rst_n), .inc(err_inc),  .count(err_count));
endmodule

// File: tb/tb_udp_rx_port_filter_64.sv
// tb_udp_rx_port_filter_64: randomized frames against a frame-level model; expected headers and
// beats are queued by the driver and popped by an independent monitor.
module tb_udp_rx_port_filter_64;
   localparam int CW  = 4;
   localparam int SAT = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [15:0]   cfg_port;
   logic          cfg_enable;
   logic [CW-1:0] drop_count, err_count;
   logic          busy;

   udp_rx_port_filter_64_if s_if();
   udp_rx_port_filter_64_if m_if();

   udp_rx_port_filter_64 #(.CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_port(cfg_port), .cfg_enable(cfg_enable),
      .s(s_if), .m(m_if), .drop_count(drop_count), .err_count(err_count), .busy(busy)
   );

   always #5 clk = ~clk;

   int          n_chk = 0, n_pass = 0;
   int          exp_drop = 0, exp_err = 0;
   bit          rand_ready = 1'b0;
   logic [79:0] hq[$];
   logic [73:0] bq[$];
   logic [79:0] h_exp;
   logic [73:0] b_exp;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   always @(posedge clk) begin
      #1;
      m_if.hdr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      m_if.tready    = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   always @(negedge clk) if (rst_n) begin
      if (m_if.hdr_valid && m_if.hdr_ready) begin
         chk("hdr_expected", hq.size() != 0, 1);
         if (hq.size() != 0) begin
            h_exp = hq.pop_front();
            chk("hdr_fields", {m_if.source_ip, m_if.source_port, m_if.dest_port, m_if.length}, h_exp);
         end
      end
      if (m_if.tvalid) chk("tready_mirror", s_if.tready, m_if.tready);
      if (m_if.tvalid && m_if.tready) begin
         chk("beat_expected", bq.size() != 0, 1);
         if (bq.size() != 0) begin
            b_exp = bq.pop_front();
            chk("beat", {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser}, b_exp);
         end
      end
   end

   task automatic send_frame(input logic [15:0] dp, input logic [15:0] len, input bit scramble);
      logic [31:0] ip = $urandom;
      logic [15:0] sp = 16'($urandom);
      int          rem = (len < 16'd8) ? 0 : int'(len) - 8;
      int          nb = (rem + 7) / 8;
      bit          fwd = 1'b0;
      int          k;
      if (nb == 0) nb = 1;
      if (len < 16'd8) exp_err = (exp_err < SAT) ? exp_err + 1 : SAT;
      else if (!cfg_enable || dp != cfg_port) exp_drop = (exp_drop < SAT) ? exp_drop + 1 : SAT;
      else fwd = 1'b1;
      s_if.hdr_valid   = 1'b1;
      s_if.source_ip   = ip;
      s_if.source_port = sp;
      s_if.dest_port   = dp;
      s_if.length      = len;
      for (k = 0; k < 200; k++) begin
         @(negedge clk);
         if (s_if.hdr_ready) break;
      end
      chk("hdr_accept", s_if.hdr_ready, 1);
      @(posedge clk); #1;
      s_if.hdr_valid = 1'b0;
      chk("hdr_valid_latency", m_if.hdr_valid, fwd);
      chk("drop_count", drop_count, exp_drop);
      chk("err_count", err_count, exp_err);
      if (fwd) hq.push_back({ip, sp, dp, len - 16'd8});
      if (scramble) begin
         cfg_port   = 16'($urandom);
         cfg_enable = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < nb; i++) begin
         logic [63:0] d = {$urandom, $urandom};
         int          b = (rem > 8) ? 8 : rem;
         logic [7:0]  kp = 8'((1 << b) - 1);
         bit          last = (i == nb - 1);
         bit          u = last && ($urandom_range(0, 3) == 0);
         rem -= b;
         if (rand_ready && $urandom_range(0, 2) == 0) begin
            s_if.tvalid = 1'b0;
            @(posedge clk); #1;
         end
         s_if.tvalid = 1'b1;
         s_if.tdata  = d;
         s_if.tkeep  = kp;
         s_if.tlast  = last;
         s_if.tuser  = u;
         if (fwd) bq.push_back({d, kp, last, u});
         for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (s_if.tready) break;
         end
         chk("beat_accept", s_if.tready, 1);
         @(posedge clk); #1;
      end
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      chk("idle_reentry", s_if.hdr_ready, 1);
      chk("busy_idle", busy, 0);
   endtask

   initial begin
      logic [15:0] dp, len;
      s_if.hdr_valid = 1'b0; s_if.source_ip = '0; s_if.source_port = '0;
      s_if.dest_port = '0; s_if.length = '0;
      s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
      m_if.hdr_ready = 1'b1; m_if.tready = 1'b1;
      cfg_port = 16'h1234; cfg_enable = 1'b1;
      #2;
      chk("rst_hdr_ready", s_if.hdr_ready, 0);
      chk("rst_s_tready", s_if.tready, 0);
      chk("rst_m_hdr_valid", m_if.hdr_valid, 0);
      chk("rst_m_tvalid", m_if.tvalid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_counts", {drop_count, err_count}, 0);
      chk("rst_hdr_regs", {m_if.source_ip, m_if.source_port, m_if.dest_port, m_if.length}, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("hdr_ready_idle", s_if.hdr_ready, 1);
      send_frame(16'h1234, 16'd32, 1'b0);
      send_frame(16'h4321, 16'd24, 1'b0);
      send_frame(16'h1234, 16'd4, 1'b0);
      rand_ready = 1'b1;
      repeat (4) send_frame(16'h1234, 16'($urandom_range(8, 64)), 1'b0);
      for (int i = 0; i < 40; i++) begin
         cfg_port   = $urandom_range(0, 1) ? 16'h1234 : 16'($urandom);
         cfg_enable = $urandom_range(0, 9) != 0;
         dp  = $urandom_range(0, 1) ? cfg_port : 16'($urandom);
         len = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 9)) : 16'($urandom_range(8, 72));
         send_frame(dp, len, 1'b1);
      end
      rand_ready = 1'b0;
      cfg_port = 16'h1234; cfg_enable = 1'b1;
      s_if.hdr_valid = 1'b1; s_if.source_ip = 32'hC0A80001; s_if.source_port = 16'd5000;
      s_if.dest_port = 16'h1234; s_if.length = 16'd48;
      @(posedge clk); #1;
      s_if.hdr_valid = 1'b0;
      hq.push_back({32'hC0A80001, 16'd5000, 16'h1234, 16'd40});
      s_if.tvalid = 1'b1; s_if.tdata = 64'h0123456789ABCDEF; s_if.tkeep = 8'hFF;
      s_if.tlast = 1'b0; s_if.tuser = 1'b0;
      bq.push_back({64'h0123456789ABCDEF, 8'hFF, 1'b0, 1'b0});
      @(posedge clk);
      @(posedge clk); #1;
      s_if.tdata = 64'hFEDCBA9876543210;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_m_tvalid", m_if.tvalid, 0);
      chk("midrst_m_hdr_valid", m_if.hdr_valid, 0);
      chk("midrst_s_tready", s_if.tready, 0);
      chk("midrst_hdr_ready", s_if.hdr_ready, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_regs", {m_if.source_ip, m_if.length, drop_count, err_count}, 0);
      s_if.tvalid = 1'b0;
      exp_drop = 0; exp_err = 0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("postrst_hdr_ready", s_if.hdr_ready, 1);
      chk("postrst_busy", busy, 0);
      repeat (SAT + 3) send_frame(16'h4321, 16'd16, 1'b0);
      chk("drop_saturated", drop_count, SAT);
      repeat (SAT + 2) send_frame(16'h1234, 16'd3, 1'b0);
      chk("err_saturated", err_count, SAT);
      send_frame(16'h1234, 16'd40, 1'b0);
      repeat (5) @(posedge clk);
      chk("hdr_queue_drained", hq.size(), 0);
      chk("beat_queue_drained", bq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
